// File: rtl/bank_strobe_decoder.sv
// bank_strobe_decoder: qualifies banked lane strobes on x and queues {sel, en} through a small FIFO.
// Define BANK_STROBE_SYNC_EN to pass x through a 2-flop synchronizer (reset to all ones) before decode.
module bank_strobe_decoder #(
  parameter int N           = 4,
  parameter int QUAL_CYCLES = 2,
  parameter int FIFO_DEPTH  = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2*N-1:0]   x,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sel,
  output logic [N-1:0]     out_en,
  output logic             err_both,
  output logic             err_ovf,
  output logic [CNT_W-1:0] strobe_cnt
);
  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;
  logic [2*N-1:0] xs;
`ifdef BANK_STROBE_SYNC_EN
  logic [2*N-1:0] s1, s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= x;
      s2 <= s1;
    end
  assign xs = s2;
`else
  assign xs = x;
`endif
  logic [N-1:0] lo, hi, cand_en, lat_en, lat_en_n;
  logic lo_act, hi_act, is_idle, is_both, same, lat_sel, lat_sel_n, push, set_both;
  logic [QW-1:0] qcnt, qcnt_n;
  state_t state, state_n;
  assign lo      = ~xs[N-1:0];
  assign hi      = ~xs[2*N-1:N];
  assign lo_act  = |lo;
  assign hi_act  = |hi;
  assign is_idle = !lo_act && !hi_act;
  assign is_both = lo_act && hi_act;
  assign cand_en = hi_act ? hi : lo;
  assign same    = (hi_act == lat_sel) && (cand_en == lat_en);
  always_comb begin
    state_n   = state;
    lat_sel_n = lat_sel;
    lat_en_n  = lat_en;
    qcnt_n    = qcnt;
    push      = 1'b0;
    set_both  = 1'b0;
    case (state)
      IDLE:
        if (is_both) begin
          set_both = 1'b1;
          state_n  = HOLD;
        end else if (!is_idle) begin
          lat_sel_n = hi_act;
          lat_en_n  = cand_en;
          qcnt_n    = QW'(1);
          push      = QUAL_CYCLES == 1;
          state_n   = QUAL_CYCLES == 1 ? HOLD : QUAL;
        end
      QUAL:
        if (is_idle) state_n = IDLE;
        else if (is_both) begin
          set_both = 1'b1;
          state_n  = HOLD;
        end else if (!same) begin
          lat_sel_n = hi_act;
          lat_en_n  = cand_en;
          qcnt_n    = QW'(1);
        end else begin
          qcnt_n  = qcnt + QW'(1);
          push    = qcnt_n == QW'(QUAL_CYCLES);
          state_n = push ? HOLD : QUAL;
        end
      HOLD: state_n = is_idle ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      lat_sel <= 1'b0;
      lat_en  <= '0;
      qcnt    <= '0;
    end else begin
      state   <= state_n;
      lat_sel <= lat_sel_n;
      lat_en  <= lat_en_n;
      qcnt    <= qcnt_n;
    end
  // Push data is always the current candidate: it equals the latch whenever push fires.
  logic [N:0] mem [FIFO_DEPTH];
  logic [N:0] last;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, pop, accept, ovf;
  assign full      = count == CW'(FIFO_DEPTH);
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign accept    = push && (!full || pop);
  assign ovf       = push && full && !pop;
  assign {out_sel, out_en} = out_valid ? mem[rd_ptr] : last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      last       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_both   <= 1'b0;
      err_ovf    <= 1'b0;
      strobe_cnt <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {hi_act, cand_en};
        wr_ptr      <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        last   <= mem[rd_ptr];
        rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      end
      count      <= count + CW'(accept) - CW'(pop);
      err_both   <= set_both || (err_both && !clr);
      err_ovf    <= ovf || (err_ovf && !clr);
      strobe_cnt <= clr ? (accept ? CNT_W'(1) : '0)
                        : (accept && strobe_cnt != CNT_MAX ? strobe_cnt + CNT_W'(1) : strobe_cnt);
    end
endmodule

// File: tb/tb_bank_strobe_decoder.sv
// tb_bank_strobe_decoder: directed scenario tests for bank_strobe_decoder (N=4, QUAL_CYCLES=2, FIFO_DEPTH=2).
module tb_bank_strobe_decoder;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [7:0] x = 8'hFF;
  logic out_valid, out_sel, err_both, err_ovf;
  logic [3:0] out_en;
  logic [15:0] strobe_cnt;
  int checks = 0, failures = 0;

  bank_strobe_decoder dut (
    .clk(clk), .rst_n(rst_n), .x(x), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_en(out_en), .err_both(err_both), .err_ovf(err_ovf), .strobe_cnt(strobe_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] v);
    x = v;
    step(2);
    x = 8'hFF;
    step(1);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, out_sel, out_en, err_both, err_ovf, strobe_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%b en=%h eb=%b eo=%b cnt=%0d want all 0",
               out_valid, out_sel, out_en, err_both, err_ovf, strobe_cnt);
    end
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single;
    x = 8'hFA;
    step(1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    step(1);
    checks++;
    if ({out_valid, out_sel, out_en} !== {1'b1, 1'b0, 4'h5}) begin
      failures++; $display("FAIL single_head got v=%b s=%b en=%h want v=1 s=0 en=5", out_valid, out_sel, out_en);
    end
    checks++;
    if (strobe_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt got %0d want 1", strobe_cnt); end
    x = 8'hFF;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, out_en} !== {1'b0, 4'h5}) begin
      failures++; $display("FAIL single_pop_hold got v=%b en=%h want v=0 en=5", out_valid, out_en);
    end
  endtask

  task automatic test_glitch;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    x = 8'hEF;
    step(1);
    x = 8'hFF;
    step(2);
    checks++;
    if ({out_valid, strobe_cnt, err_both, err_ovf} !== '0) begin
      failures++; $display("FAIL glitch got v=%b cnt=%0d eb=%b eo=%b want all 0", out_valid, strobe_cnt, err_both, err_ovf);
    end
  endtask

  task automatic test_both;
    x = 8'h5A;
    step(1);
    checks++;
    if ({err_both, out_valid} !== 2'b10) begin
      failures++; $display("FAIL both_flag got eb=%b v=%b want eb=1 v=0", err_both, out_valid);
    end
    x = 8'hFF;
    step(1);
    x = 8'h7F;
    step(3);
    checks++;
    if ({out_valid, out_sel, out_en, strobe_cnt} !== {1'b1, 1'b1, 4'h8, 16'd1}) begin
      failures++; $display("FAIL upper_head got v=%b s=%b en=%h cnt=%0d want v=1 s=1 en=8 cnt=1",
                           out_valid, out_sel, out_en, strobe_cnt);
    end
    x = 8'hFF;
    clr = 1'b1;
    out_ready = 1'b1;
    step(1);
    clr = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({err_both, out_valid, strobe_cnt} !== '0) begin
      failures++; $display("FAIL both_clr got eb=%b v=%b cnt=%0d want 0 0 0", err_both, out_valid, strobe_cnt);
    end
  endtask

  task automatic test_overflow;
    strobe(8'hFE);
    strobe(8'hFD);
    strobe(8'hEF);
    checks++;
    if ({err_ovf, strobe_cnt} !== {1'b1, 16'd2}) begin
      failures++; $display("FAIL ovf_flag got eo=%b cnt=%0d want eo=1 cnt=2", err_ovf, strobe_cnt);
    end
    checks++;
    if ({out_valid, out_sel, out_en} !== {1'b1, 1'b0, 4'h1}) begin
      failures++; $display("FAIL ovf_head0 got v=%b s=%b en=%h want v=1 s=0 en=1", out_valid, out_sel, out_en);
    end
    out_ready = 1'b1;
    step(1);
    checks++;
    if ({out_valid, out_sel, out_en} !== {1'b1, 1'b0, 4'h2}) begin
      failures++; $display("FAIL ovf_head1 got v=%b s=%b en=%h want v=1 s=0 en=2", out_valid, out_sel, out_en);
    end
    step(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_clr_event;
    x = 8'hFE;
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    x = 8'hFF;
    checks++;
    if ({err_ovf, strobe_cnt, out_valid} !== {1'b0, 16'd1, 1'b1}) begin
      failures++; $display("FAIL clr_with_push got eo=%b cnt=%0d v=%b want eo=0 cnt=1 v=1", err_ovf, strobe_cnt, out_valid);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop;
    strobe(8'hFE);
    strobe(8'hFD);
    x = 8'hF7;
    step(1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    x = 8'hFF;
    checks++;
    if ({err_ovf, strobe_cnt, out_valid, out_en} !== {1'b0, 16'd4, 1'b1, 4'h2}) begin
      failures++; $display("FAIL full_pop got eo=%b cnt=%0d v=%b en=%h want eo=0 cnt=4 v=1 en=2",
                           err_ovf, strobe_cnt, out_valid, out_en);
    end
    out_ready = 1'b1;
    step(1);
    checks++;
    if ({out_valid, out_sel, out_en} !== {1'b1, 1'b0, 4'h8}) begin
      failures++; $display("FAIL full_pop_order got v=%b s=%b en=%h want v=1 s=0 en=8", out_valid, out_sel, out_en);
    end
    step(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL full_pop_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_long_hold;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    x = 8'hFB;
    step(10);
    x = 8'hFF;
    step(1);
    checks++;
    if ({out_valid, out_sel, out_en, strobe_cnt} !== {1'b1, 1'b0, 4'h4, 16'd1}) begin
      failures++; $display("FAIL long_hold got v=%b s=%b en=%h cnt=%0d want v=1 s=0 en=4 cnt=1",
                           out_valid, out_sel, out_en, strobe_cnt);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL long_hold_single got v=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    x = 8'hFE;
    step(1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sel, out_en, err_both, err_ovf, strobe_cnt} !== '0) begin
      failures++; $display("FAIL reset_mid got v=%b s=%b en=%h eb=%b eo=%b cnt=%0d want all 0",
                           out_valid, out_sel, out_en, err_both, err_ovf, strobe_cnt);
    end
    x = 8'hFF;
    step(1);
    rst_n = 1'b1;
    step(3);
    checks++;
    if ({out_valid, strobe_cnt} !== '0) begin
      failures++; $display("FAIL reset_release got v=%b cnt=%0d want 0 0", out_valid, strobe_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_glitch;
    test_both;
    test_overflow;
    test_clr_event;
    test_full_pop;
    test_long_hold;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
